// File: rtl/gpio_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_ctrl_pkg                                                |
// | Description : Shared mode encoding, config-word field map and address      |
// |               helpers for the multi-channel GPIO controller.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package gpio_ctrl_pkg;

  // Per-channel operating mode, stored in config word bits [1:0]
  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_FOLLOW  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_PWM     = 2'd3
  } mode_e;

  // Config word field positions
  localparam int CFG_DATA_W     = 32;
  localparam int CFG_MODE_LSB   = 0;
  localparam int CFG_MODE_W     = 2;
  localparam int CFG_LEVEL_BIT  = 2;
  localparam int CFG_INVERT_BIT = 3;
  localparam int CFG_DUTY_LSB   = 8;
  localparam int CFG_LEN_LSB    = 16;

  // The shared PWM period register sits at the address just past the last channel
  function automatic int period_addr(input int num_ch);
    return num_ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_ch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_ch_unit                                                 |
// | Description : One GPIO channel: config register, one-shot counter, mode    |
// |               mux, optional inversion and registered output.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpio_ch_unit
  import gpio_ctrl_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PLS_W = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [CFG_DATA_W-1:0] cfg_data_i,
  input  logic                  trig_s2_i,
  input  logic                  trig_rise_i,
  input  logic [CNT_W-1:0]      pwm_cnt_i,
  output logic                  gpio_o,
  output logic                  pulse_active_o
);

  mode_e              mode_q, mode_d;
  logic               level_q, level_d;
  logic               invert_q, invert_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [PLS_W-1:0]   len_q, len_d;
  logic [PLS_W-1:0]   pcnt_q, pcnt_d;
  logic               gpio_q, gpio_d;
  logic               raw;

  // Reserved config bits carry no meaning; reduce them so they are consumed
  logic cfg_unused;
  assign cfg_unused = ^cfg_data_i;

  // Config capture and one-shot counter; a write aborts any running pulse and
  // takes priority over a coincident trigger edge
  always_comb begin
    mode_d   = mode_q;
    level_d  = level_q;
    invert_d = invert_q;
    duty_d   = duty_q;
    len_d    = len_q;
    pcnt_d   = pcnt_q;
    if (cfg_we_i) begin
      mode_d   = mode_e'(cfg_data_i[CFG_MODE_LSB +: CFG_MODE_W]);
      level_d  = cfg_data_i[CFG_LEVEL_BIT];
      invert_d = cfg_data_i[CFG_INVERT_BIT];
      duty_d   = cfg_data_i[CFG_DUTY_LSB +: CNT_W];
      len_d    = cfg_data_i[CFG_LEN_LSB +: PLS_W];
      pcnt_d   = '0;
    end else if (trig_rise_i && (mode_q == MODE_ONESHOT)) begin
      pcnt_d   = len_q;
    end else if (pcnt_q != '0) begin
      pcnt_d   = pcnt_q - PLS_W'(1);
    end
  end

  // Mode mux and inversion feeding the output register
  always_comb begin
    raw = 1'b0;
    case (mode_q)
      MODE_STATIC:  raw = level_q;
      MODE_FOLLOW:  raw = trig_s2_i;
      MODE_ONESHOT: raw = (pcnt_q != '0);
      MODE_PWM:     raw = (pwm_cnt_i < duty_q);
      default:      raw = 1'b0;
    endcase
    gpio_d = raw ^ invert_q;
  end

  // Channel state registers
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      mode_q   <= MODE_STATIC;
      level_q  <= 1'b0;
      invert_q <= 1'b0;
      duty_q   <= '0;
      len_q    <= '0;
      pcnt_q   <= '0;
      gpio_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      level_q  <= level_d;
      invert_q <= invert_d;
      duty_q   <= duty_d;
      len_q    <= len_d;
      pcnt_q   <= pcnt_d;
      gpio_q   <= gpio_d;
    end
  end

  assign gpio_o         = gpio_q;
  assign pulse_active_o = (pcnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_ctrl_multi                                              |
// | Description : NUM_CH independently programmable GPIO outputs with static,  |
// |               trigger-follow, one-shot and PWM modes. Holds the shared     |
// |               trigger synchroniser, PWM period register and PWM counter.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// ADDR_W must be wide enough that 2**ADDR_W > NUM_CH so the period register
// has its own address.
module gpio_ctrl_multi
  import gpio_ctrl_pkg::*;
#(
  parameter int NUM_CH = 45,
  parameter int CNT_W  = 8,
  parameter int PLS_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic                  gpio_start_trigger_i,
  input  logic                  cfg_we_i,
  input  logic [ADDR_W-1:0]     cfg_addr_i,
  input  logic [CFG_DATA_W-1:0] cfg_data_i,
  output logic [NUM_CH-1:0]     gpio_o,
  output logic [NUM_CH-1:0]     pulse_active_o
);

  localparam int PERIOD_ADDR = period_addr(NUM_CH);

  logic             trig_s1_q, trig_s1_d;
  logic             trig_s2_q, trig_s2_d;
  logic             trig_s3_q, trig_s3_d;
  logic             trig_rise;
  logic             period_we;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;

  assign period_we = cfg_we_i && (cfg_addr_i == ADDR_W'(PERIOD_ADDR));
  assign trig_rise = trig_s2_q & ~trig_s3_q;

  // Trigger synchroniser chain, period register and wrapping PWM counter
  always_comb begin
    trig_s1_d = gpio_start_trigger_i;
    trig_s2_d = trig_s1_q;
    trig_s3_d = trig_s2_q;
    period_d  = period_q;
    pwm_cnt_d = pwm_cnt_q;
    if (period_we) begin
      period_d  = cfg_data_i[CNT_W-1:0];
      pwm_cnt_d = '0;
    end else if (pwm_cnt_q >= period_q) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
    end
  end

  // Shared state registers
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
      period_q  <= '0;
      pwm_cnt_q <= '0;
    end else begin
      trig_s1_q <= trig_s1_d;
      trig_s2_q <= trig_s2_d;
      trig_s3_q <= trig_s3_d;
      period_q  <= period_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we_i && (cfg_addr_i == ADDR_W'(i));

    gpio_ch_unit #(
      .CNT_W (CNT_W),
      .PLS_W (PLS_W)
    ) u_ch (
      .sys_clk_i      (sys_clk_i),
      .rst_i          (rst_i),
      .cfg_we_i       (ch_we),
      .cfg_data_i     (cfg_data_i),
      .trig_s2_i      (trig_s2_q),
      .trig_rise_i    (trig_rise),
      .pwm_cnt_i      (pwm_cnt_q),
      .gpio_o         (gpio_o[i]),
      .pulse_active_o (pulse_active_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gpio_ctrl_multi                                           |
// | Description : Scoreboard bench for gpio_ctrl_multi: directed scenarios     |
// |               followed by random traffic, checked every cycle against a    |
// |               timeline reference model.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gpio_ctrl_multi;

  localparam int NUM_CH      = 45;
  localparam int CNT_W       = 8;
  localparam int PLS_W       = 16;
  localparam int ADDR_W      = 6;
  localparam int PERIOD_ADDR = NUM_CH;

  logic              clk = 1'b0;
  logic              rst;
  logic              trig;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic [NUM_CH-1:0] gpio;
  logic [NUM_CH-1:0] pact;

  always #5 clk = ~clk;

  gpio_ctrl_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PLS_W  (PLS_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .sys_clk_i            (clk),
    .rst_i                (rst),
    .gpio_start_trigger_i (trig),
    .cfg_we_i             (we),
    .cfg_addr_i           (addr),
    .cfg_data_i           (data),
    .gpio_o               (gpio),
    .pulse_active_o       (pact)
  );

  typedef struct {
    logic [NUM_CH-1:0] g;
    logic [NUM_CH-1:0] a;
    int                edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: configuration as seen after the latest clock edge, the
  // last three sampled trigger values, the edge on which each channel's pulse
  // ends, and the edge at which the PWM phase was last restarted.
  int m_mode  [NUM_CH];
  bit m_level [NUM_CH];
  bit m_inv   [NUM_CH];
  int m_duty  [NUM_CH];
  int m_len   [NUM_CH];
  int m_end   [NUM_CH];
  int m_period = 0;
  int m_base   = 0;
  int m_n      = 0;
  bit h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  int hi_cnt [NUM_CH];
  bit cur_trig = 1'b0;

  // Expected outputs just after clock edge number m_n given this cycle's inputs
  task automatic model_step(input bit r, input bit w, input int a, input logic [31:0] d,
                            input bit t, output logic [NUM_CH-1:0] eg,
                            output logic [NUM_CH-1:0] ea);
    int  n;
    bit  rise;
    bit  rv;
    n  = m_n;
    eg = '0;
    ea = '0;
    if (r) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = 0; m_level[c] = 1'b0; m_inv[c] = 1'b0;
        m_duty[c] = 0; m_len[c] = 0; m_end[c] = n - 1;
      end
      m_period = 0;
      m_base   = n;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      // A trigger first sampled at edge k is recognised as a rising edge at k+2
      rise = h1 && !h2;
      for (int c = 0; c < NUM_CH; c++) begin
        case (m_mode[c])
          0:       rv = m_level[c];
          1:       rv = h1;
          2:       rv = (n - 1 <= m_end[c]);
          default: rv = (((n - 1 - m_base) % (m_period + 1)) < m_duty[c]);
        endcase
        eg[c] = rv ^ m_inv[c];
        if (w && a == c)                 m_end[c] = n - 1;
        else if (rise && m_mode[c] == 2) m_end[c] = n - 1 + m_len[c];
        ea[c] = (n <= m_end[c]);
      end
      if (w && a < NUM_CH) begin
        m_mode[a]  = int'(d[1:0]);
        m_level[a] = d[2];
        m_inv[a]   = d[3];
        m_duty[a]  = int'(d[15:8]);
        m_len[a]   = int'(d[31:16]);
      end else if (w && a == PERIOD_ADDR) begin
        m_period = int'(d[7:0]);
        m_base   = n;
      end
      h2 = h1; h1 = h0; h0 = t;
    end
    m_n = m_n + 1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] mode, input logic lvl, input logic inv,
                                     input logic [7:0] duty, input logic [15:0] len);
    return {len, duty, 4'b0000, inv, lvl, mode};
  endfunction

  // One clock cycle of stimulus: tally observed highs, drive, predict, enqueue
  task automatic cyc(input bit r, input bit w, input int a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) if (gpio[c] === 1'b1) hi_cnt[c]++;
    rst  = r;
    we   = w;
    addr = ADDR_W'(a);
    data = d;
    trig = cur_trig;
    e.edge_no = m_n;
    model_step(r, w, a, d, cur_trig, e.g, e.a);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic clear_cnt();
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (gpio !== e.g) begin
          n_fail++;
          $display("FAIL gpio_o edge %0d: got %h expected %h", e.edge_no, gpio, e.g);
        end
        n_assert++;
        if (pact !== e.a) begin
          n_fail++;
          $display("FAIL pulse_active_o edge %0d: got %h expected %h", e.edge_no, pact, e.a);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int          total;
    bit          r;
    bit          w;
    int          a;
    logic [31:0] d;
    rst = 1'b1; we = 1'b0; addr = '0; data = '0; trig = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_end[c] = -1;
    clear_cnt();
    repeat (3) cyc(1'b1, 1'b0, 0, 32'd0);
    chk("reset_gpio_initial", 64'(gpio), 64'd0);

    // STATIC: ch0 high two cycles after the write, nothing else moves
    wr(0, mk(2'd0, 1'b1, 1'b0, 8'd0, 16'd0));
    idle(1); chk("static_lat_1cyc", 64'(gpio), 64'd0);
    idle(1); chk("static_lat_2cyc", 64'(gpio), 64'd1);

    // FOLLOW: ch5 plain, ch6 inverted; trigger high for 10 cycles
    wr(5, mk(2'd1, 1'b0, 1'b0, 8'd0, 16'd0));
    wr(6, mk(2'd1, 1'b0, 1'b1, 8'd0, 16'd0));
    idle(4); clear_cnt();
    cur_trig = 1'b1; idle(3);
    chk("follow_lat_pre", 64'(gpio[5]), 64'd0);
    idle(1);
    chk("follow_lat", 64'(gpio[5]), 64'd1);
    chk("follow_inv_lat", 64'(gpio[6]), 64'd0);
    idle(6); cur_trig = 1'b0; idle(10);
    chk("follow_hi_cycles", 64'(hi_cnt[5]), 64'd10);
    chk("follow_inv_hi_cycles", 64'(hi_cnt[6]), 64'd10);

    // ONESHOT len=5, then retrigger three samples later, then len=0
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd5));
    idle(3); clear_cnt();
    cur_trig = 1'b1; idle(3); cur_trig = 1'b0; idle(12);
    chk("oneshot_len5", 64'(hi_cnt[16]), 64'd5);
    clear_cnt();
    cur_trig = 1'b1; idle(1); cur_trig = 1'b0; idle(2);
    cur_trig = 1'b1; idle(1); cur_trig = 1'b0; idle(16);
    chk("oneshot_retrig", 64'(hi_cnt[16]), 64'd8);
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd0));
    idle(3); clear_cnt();
    cur_trig = 1'b1; idle(3); cur_trig = 1'b0; idle(8);
    chk("oneshot_len0", 64'(hi_cnt[16]), 64'd0);

    // PWM period 9: duty 3, 0 and 12 (above period)
    wr(PERIOD_ADDR, 32'd9);
    wr(20, mk(2'd3, 1'b0, 1'b0, 8'd3, 16'd0));
    wr(21, mk(2'd3, 1'b0, 1'b0, 8'd0, 16'd0));
    wr(22, mk(2'd3, 1'b0, 1'b0, 8'd12, 16'd0));
    idle(3); clear_cnt(); idle(30);
    chk("pwm_duty3", 64'(hi_cnt[20]), 64'd9);
    chk("pwm_duty0", 64'(hi_cnt[21]), 64'd0);
    chk("pwm_duty_gt_period", 64'(hi_cnt[22]), 64'd30);

    // Long pulse aborted by a config write
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd100));
    idle(3);
    cur_trig = 1'b1; idle(3); cur_trig = 1'b0; idle(20);
    chk("abort_pre_active", 64'(pact[16]), 64'd1);
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd100));
    idle(1); chk("abort_active_cleared", 64'(pact[16]), 64'd0);
    idle(2); chk("abort_gpio_low", 64'(gpio[16]), 64'd0);

    // Trigger edge coinciding with a write to ch16; ch17 still pulses
    wr(17, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd4));
    idle(3); clear_cnt();
    cur_trig = 1'b1; idle(2);
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd10));
    cur_trig = 1'b0; idle(12);
    chk("coincident_edge_dropped", 64'(hi_cnt[16]), 64'd0);
    chk("coincident_other_ch", 64'(hi_cnt[17]), 64'd4);

    // Reset mid-pulse and mid-PWM
    wr(16, mk(2'd2, 1'b0, 1'b0, 8'd0, 16'd50));
    idle(2);
    cur_trig = 1'b1; idle(3); cur_trig = 1'b0; idle(5);
    chk("pre_reset_active", 64'(pact[16]), 64'd1);
    cyc(1'b1, 1'b0, 0, 32'd0);
    idle(1);
    chk("reset_gpio", 64'(gpio), 64'd0);
    chk("reset_pact", 64'(pact), 64'd0);
    clear_cnt();
    cur_trig = 1'b1; idle(4); cur_trig = 1'b0; idle(6);
    total = 0;
    for (int c = 0; c < NUM_CH; c++) total += hi_cnt[c];
    chk("reset_cfg_cleared", 64'(total), 64'd0);

    // Write beyond the period address is ignored (period stays 0)
    wr(20, mk(2'd3, 1'b0, 1'b0, 8'd3, 16'd0));
    idle(3);
    wr(NUM_CH + 1, 32'hFFFF_FFFF);
    idle(2); clear_cnt(); idle(20);
    chk("bad_addr_pwm_unchanged", 64'(hi_cnt[20]), 64'd20);
    total = 0;
    for (int c = 0; c < NUM_CH; c++) if (c != 20) total += hi_cnt[c];
    chk("bad_addr_others_low", 64'(total), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      w = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) a = NUM_CH + int'($urandom_range(0, 18));
      else                           a = int'($urandom_range(0, NUM_CH - 1));
      d = $urandom;
      if (a == PERIOD_ADDR) begin
        d[7:0] = 8'($urandom_range(0, 15));
      end else begin
        d[15:8]  = 8'($urandom_range(0, 17));
        d[31:16] = 16'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 5) == 0) cur_trig = ~cur_trig;
      cyc(r, w, a, d);
    end

    idle(3);
    @(posedge clk);
    #2;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
